ascii_segment_display: RTL and testbench

- Consumer end of the character-stepping path: watches the held 8-bit ASCII code produced by the switch-driven character generator and shows the last two characters on the Go Board's two 7-segment digits.
- Each new character is detected as a change of value (no valid strobe) and shifted in from the right. The previous right digit moves to the left digit.
- Characters outside the supported set produce a blinking error glyph and an error flag.

---
 rtl/ascii_segment_display.sv | 151 +++++++++++++++
 tb/tb_ascii_segment_display.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ascii_segment_display.sv
// rtl/ascii_segment_display.sv - shows the last two ASCII characters on two 7-segment digits
module ascii_segment_display #(
  parameter int unsigned BLINK_HALF_PERIOD = 12500000
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic [7:0] i_Character,
  output logic [6:0] o_Segment1,
  output logic [6:0] o_Segment2,
  output logic       o_Accept,
  output logic       o_Error
);

  // Active-low glyph constants, bit6=A .. bit0=G.
  localparam logic [6:0] GLYPH_BLANK = 7'h7F;
  localparam logic [6:0] GLYPH_DASH  = 7'h7E;
  localparam logic [6:0] GLYPH_ERROR = 7'h36;

  // Last count value of a blink half-period; the counter wraps here.
  localparam logic [23:0] BLINK_LAST = 24'(BLINK_HALF_PERIOD - 1);

  // Capture stage: change detector and the two-character shift register.
  logic [7:0]  last_char_q, last_char_d;
  logic [7:0]  tens_q, tens_d;
  logic [7:0]  ones_q, ones_d;
  logic        capture_q, capture_d;

  // Display stage: registered glyphs, flags and blink state.
  logic [6:0]  seg1_q, seg1_d;
  logic [6:0]  seg2_q, seg2_d;
  logic        accept_q, accept_d;
  logic        error_q, error_d;
  logic [23:0] blink_cnt_q, blink_cnt_d;
  logic        blink_on_q, blink_on_d;

  logic        char_changed;
  logic        tens_err;
  logic        ones_err;
  logic        any_err;

  // Hex digits (either case), blank, space and dash are the displayable set.
  function automatic logic is_supported(input logic [7:0] c);
    logic ok;
    ok = 1'b0;
    if (c >= 8'h30 && c <= 8'h39) ok = 1'b1;
    if (c >= 8'h41 && c <= 8'h46) ok = 1'b1;
    if (c >= 8'h61 && c <= 8'h66) ok = 1'b1;
    if (c == 8'h00 || c == 8'h20 || c == 8'h2D) ok = 1'b1;
    return ok;
  endfunction

  // ASCII to active-low segment pattern; lower-case hex renders as upper-case.
  function automatic logic [6:0] glyph(input logic [7:0] c);
    logic [6:0] g;
    case (c)
      8'h30:        g = 7'h01;  // 0
      8'h31:        g = 7'h4F;  // 1
      8'h32:        g = 7'h12;  // 2
      8'h33:        g = 7'h06;  // 3
      8'h34:        g = 7'h4C;  // 4
      8'h35:        g = 7'h24;  // 5
      8'h36:        g = 7'h20;  // 6
      8'h37:        g = 7'h0F;  // 7
      8'h38:        g = 7'h00;  // 8
      8'h39:        g = 7'h04;  // 9
      8'h41, 8'h61: g = 7'h08;  // A
      8'h42, 8'h62: g = 7'h60;  // b
      8'h43, 8'h63: g = 7'h31;  // C
      8'h44, 8'h64: g = 7'h42;  // d
      8'h45, 8'h65: g = 7'h30;  // E
      8'h46, 8'h66: g = 7'h38;  // F
      8'h00, 8'h20: g = GLYPH_BLANK;
      8'h2D:        g = GLYPH_DASH;
      default:      g = GLYPH_ERROR;
    endcase
    return g;
  endfunction

  // Change detection and shift-in of a new character from the right.
  always_comb begin
    char_changed = (i_Character != last_char_q);
    last_char_d  = last_char_q;
    tens_d       = tens_q;
    ones_d       = ones_q;
    capture_d    = char_changed;
    if (char_changed) begin
      last_char_d = i_Character;
      tens_d      = ones_q;
      ones_d      = i_Character;
    end
  end

  // Blink timing runs only while a digit is in error, so a new error starts in the on phase.
  always_comb begin
    tens_err    = !is_supported(tens_q);
    ones_err    = !is_supported(ones_q);
    any_err     = tens_err || ones_err;
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    if (!any_err) begin
      blink_cnt_d = 24'd0;
      blink_on_d  = 1'b1;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = 24'd0;
      blink_on_d  = !blink_on_q;
    end else begin
      blink_cnt_d = blink_cnt_q + 24'd1;
    end
  end

  // Registered decode; only digits holding unsupported codes are blanked in the off phase.
  always_comb begin
    seg1_d   = (tens_err && !blink_on_q) ? GLYPH_BLANK : glyph(tens_q);
    seg2_d   = (ones_err && !blink_on_q) ? GLYPH_BLANK : glyph(ones_q);
    error_d  = any_err;
    accept_d = capture_q;
  end

  // State update; reset clears everything, including any change seen during reset.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      last_char_q <= 8'h00;
      tens_q      <= 8'h00;
      ones_q      <= 8'h00;
      capture_q   <= 1'b0;
      seg1_q      <= GLYPH_BLANK;
      seg2_q      <= GLYPH_BLANK;
      accept_q    <= 1'b0;
      error_q     <= 1'b0;
      blink_cnt_q <= 24'd0;
      blink_on_q  <= 1'b1;
    end else begin
      last_char_q <= last_char_d;
      tens_q      <= tens_d;
      ones_q      <= ones_d;
      capture_q   <= capture_d;
      seg1_q      <= seg1_d;
      seg2_q      <= seg2_d;
      accept_q    <= accept_d;
      error_q     <= error_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
    end
  end

  assign o_Segment1 = seg1_q;
  assign o_Segment2 = seg2_q;
  assign o_Accept   = accept_q;
  assign o_Error    = error_q;

endmodule

// File: tb/tb_ascii_segment_display.sv
// tb/tb_ascii_segment_display.sv - directed self-checking bench for ascii_segment_display
module tb_ascii_segment_display;

  logic       clk;
  logic       rst;
  logic [7:0] ch;
  logic [6:0] seg1;
  logic [6:0] seg2;
  logic       acc;
  logic       err;

  int vectors;
  int miscompares;
  int acc_count;

  ascii_segment_display #(.BLINK_HALF_PERIOD(4)) dut (
    .i_Clk       (clk),
    .i_Reset     (rst),
    .i_Character (ch),
    .o_Segment1  (seg1),
    .o_Segment2  (seg2),
    .o_Accept    (acc),
    .o_Error     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle a little after the active edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_seg(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst = 1'b1;
    ch  = 8'h00;

    // Reset state
    tick(); tick(); tick();
    chk_seg("reset_seg1", seg1, 7'h7F);
    chk_seg("reset_seg2", seg2, 7'h7F);
    chk_bit("reset_acc", acc, 1'b0);
    chk_bit("reset_err", err, 1'b0);
    rst = 1'b0;

    // 8'h00 held: never accepted, stays blank
    acc_count = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (acc === 1'b1) acc_count++;
    end
    chk_int("zero_hold_accepts", acc_count, 0);
    chk_seg("zero_hold_seg1", seg1, 7'h7F);
    chk_seg("zero_hold_seg2", seg2, 7'h7F);
    chk_bit("zero_hold_err", err, 1'b0);

    // '1' then '2' ten cycles later
    ch = 8'h31;
    tick();
    chk_bit("one_acc_n1", acc, 1'b0);
    tick();
    chk_bit("one_acc_n2", acc, 1'b1);
    chk_seg("one_seg1", seg1, 7'h7F);
    chk_seg("one_seg2", seg2, 7'h4F);
    acc_count = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (acc === 1'b1) acc_count++;
    end
    chk_int("one_hold_accepts", acc_count, 0);
    ch = 8'h32;
    tick();
    chk_bit("two_acc_n1", acc, 1'b0);
    tick();
    chk_bit("two_acc_n2", acc, 1'b1);
    chk_seg("two_seg1", seg1, 7'h4F);
    chk_seg("two_seg2", seg2, 7'h12);
    tick();
    chk_bit("two_acc_n3", acc, 1'b0);

    // Back-to-back '0','A','a'
    ch = 8'h30;
    tick();
    ch = 8'h41;
    tick();
    chk_bit("b2b_acc0", acc, 1'b1);
    chk_seg("b2b_mid0_seg1", seg1, 7'h12);
    chk_seg("b2b_mid0_seg2", seg2, 7'h01);
    ch = 8'h61;
    tick();
    chk_bit("b2b_accA", acc, 1'b1);
    chk_seg("b2b_mid1_seg1", seg1, 7'h01);
    chk_seg("b2b_mid1_seg2", seg2, 7'h08);
    tick();
    chk_bit("b2b_acca", acc, 1'b1);
    chk_seg("b2b_fin_seg1", seg1, 7'h08);
    chk_seg("b2b_fin_seg2", seg2, 7'h08);
    tick();
    chk_bit("b2b_acc_end", acc, 1'b0);

    // Error glyph 'n' blinking on the right digit, 4 cycles per phase starting on
    ch = 8'h6E;
    tick();
    for (int k = 0; k < 12; k++) begin
      tick();
      chk_seg($sformatf("n_blink_seg2_%0d", k), seg2, ((k / 4) % 2 == 0) ? 7'h36 : 7'h7F);
      chk_seg($sformatf("n_blink_seg1_%0d", k), seg1, 7'h08);
      chk_bit($sformatf("n_blink_err_%0d", k), err, 1'b1);
    end

    // '5' pushes the error glyph to the left digit; it keeps blinking
    ch = 8'h35;
    tick();
    for (int k = 0; k < 8; k++) begin
      tick();
      if (k == 0) chk_bit("five_acc", acc, 1'b1);
      chk_seg($sformatf("five_blink_seg1_%0d", k), seg1, (k >= 3 && k <= 6) ? 7'h36 : 7'h7F);
      chk_seg($sformatf("five_seg2_%0d", k), seg2, 7'h24);
      chk_bit($sformatf("five_err_%0d", k), err, 1'b1);
    end

    // '6' clears the error and stops blinking
    ch = 8'h36;
    tick();
    tick();
    chk_bit("six_acc", acc, 1'b1);
    chk_bit("six_err", err, 1'b0);
    chk_seg("six_seg1", seg1, 7'h24);
    chk_seg("six_seg2", seg2, 7'h20);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk_seg($sformatf("six_steady_seg1_%0d", k), seg1, 7'h24);
    end

    // '-' then ' '
    ch = 8'h2D;
    tick(); tick();
    chk_seg("dash_seg2", seg2, 7'h7E);
    ch = 8'h20;
    tick(); tick();
    chk_bit("space_acc", acc, 1'b1);
    chk_seg("space_seg1", seg1, 7'h7E);
    chk_seg("space_seg2", seg2, 7'h7F);
    chk_bit("space_err", err, 1'b0);

    // Reset mid-operation with "12" showing and '3' arriving during reset
    ch = 8'h31;
    tick(); tick(); tick();
    ch = 8'h32;
    tick(); tick();
    chk_seg("pre_rst_seg1", seg1, 7'h4F);
    chk_seg("pre_rst_seg2", seg2, 7'h12);
    tick();
    rst = 1'b1;
    ch  = 8'h33;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_seg($sformatf("in_rst_seg1_%0d", k), seg1, 7'h7F);
      chk_seg($sformatf("in_rst_seg2_%0d", k), seg2, 7'h7F);
      chk_bit($sformatf("in_rst_acc_%0d", k), acc, 1'b0);
    end
    rst = 1'b0;
    tick();
    chk_seg("post_rst_seg1_a", seg1, 7'h7F);
    chk_seg("post_rst_seg2_a", seg2, 7'h7F);
    chk_bit("post_rst_acc_a", acc, 1'b0);
    tick();
    chk_bit("post_rst_acc_b", acc, 1'b1);
    chk_seg("post_rst_seg1_b", seg1, 7'h7F);
    chk_seg("post_rst_seg2_b", seg2, 7'h06);
    acc_count = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (acc === 1'b1) acc_count++;
    end
    chk_int("post_rst_extra_accepts", acc_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
